bicubic_tap_mac: RTL and testbench
==================================

Name: bicubic_tap_mac

Overview:
- Consumer side of the bicubic weight generators: takes four kernel weights w0..w3 and four neighbouring pixels p0..p3, and produces one interpolated pixel per accepted beat.
- Computes sum(pi*wi), rounds, renormalises by 2^WF and clamps to the unsigned pixel range.
- Fully pipelined, one beat per clock, with valid/ready handshake on both sides.
- Sits between the weight/line-buffer stage and the output pixel stream of the scaler; instantiated once per colour channel.

Parameters:
- DATA_W, 8: unsigned pixel width.
- W_W, 18: signed weight width, two's complement.
- WF, 14: weight fraction bits; 1.0 = 2^WF = 16384.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- p0, p1, p2, p3  in  DATA_W each  unsigned neighbour pixels, p0 leftmost.
- w0, w1, w2, w3  in  W_W each  signed weights paired with p0..p3.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_pix  out  DATA_W  interpolated, clamped pixel.
- out_sat  out  1  qualified by out_valid; 1 when the result was clamped, either end.

Behaviour:
- Reset, async: all pipeline valid bits, data registers, out_valid, out_pix and out_sat clear to 0.
- Pipeline enable: en = !out_valid || out_ready. When en=0 every stage holds and in_ready=0.
- in_ready = en, combinational from out_valid/out_ready only. Never depends on in_valid.
- S1, on en: register the four products pi_ext*wi. pi_ext is zero-extended by one bit to signed. Product width PW = DATA_W+1+W_W. Register v1 <= in_valid.
- S2, on en: register s01 = prod0+prod1 and s23 = prod2+prod3, each PW+1 bits signed. v2 <= v1.
- S3, on en: compute t = s01+s23 (PW+2 bits signed) + 2^(WF-1), then r = t >>> WF (arithmetic, so rounding is half-up toward +inf).
  - r < 0: out_pix = 0, out_sat = 1.
  - r > 2^DATA_W-1: out_pix = 2^DATA_W-1, out_sat = 1.
  - Otherwise out_pix = r[DATA_W-1:0], out_sat = 0.
  - out_valid <= v2.
- Latency: exactly 3 enabled clocks from accept to out_valid. Throughput: 1 beat/clk while out_ready=1.
- Bubbles (valid=0 stages) advance like data. Stalling with bubbles inside the pipe is accepted; no bubble collapsing.
- out_pix and out_sat are stable while out_valid && !out_ready.
- Data registers may load garbage when their stage valid is 0. Only valid-qualified outputs are checked.
- No internal overflow: widths are sized for the worst case of max pixel times most-negative weight times 4.
- Mid-stream reset: in-flight beats are discarded, out_valid drops asynchronously, and in_ready=1 on the first clock after release.
- Simultaneous accept and stall are impossible by construction: in_ready=0 whenever the output is stalled.

Decomposition:
- Shared scaler package holds:
  - WF_DEFAULT = 14.
  - ONE_Q = 1<<WF.
  - HALF_Q = 1<<(WF-1).
  - Pixel and weight width constants, shared with the weight generators so the fixed-point scale is defined once.
- One natural sub-module, bicubic_round_clamp: S3 add-round-shift-saturate, parameterised by input width, DATA_W and WF. Reused by the vertical pass.

Test Plan:
- Identity: w=(0,16384,0,0), p=(10,200,30,40), out_ready=1 -> out_pix=200, out_sat=0, out_valid exactly 3 clocks after accept.
- Half-phase, a=-0.5: w=(-1024,9216,9216,-1024), p=(0,100,100,0) -> sum 1843200, out_pix=113 (112.5 rounds up), out_sat=0.
- Clamp high/low:
  - Same w, p=(0,255,255,0) -> out_pix=255, out_sat=1.
  - Same w, p=(255,0,0,255) -> out_pix=0, out_sat=1.
- Backpressure: stream 20 identity beats with p1=0..19 and continuous in_valid; drop out_ready for 5 clocks mid-stream -> in_ready=0 during the stall, outputs held, and the full sequence 0..19 is delivered in order with no loss or duplication.
- Bubbles: in_valid toggling 1,0,1,1,0 with out_ready=1 -> out_valid shows the same pattern delayed 3 clocks.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately. After release, no stale beat appears, and the first new beat emerges 3 clocks after its accept.

Source files
------------

// File: rtl/bicubic_tap_mac_pkg.sv
// bicubic_tap_mac_pkg: fixed-point scale and widths shared with the bicubic weight generators
package bicubic_tap_mac_pkg;
  localparam int PIX_W = 8;
  localparam int WGT_W = 18;
  localparam int WF_DEFAULT = 14;
  localparam int ONE_Q = 1 << WF_DEFAULT;
  localparam int HALF_Q = 1 << (WF_DEFAULT - 1);
  // Pixel zero-extended by one bit to signed, times a signed weight.
  function automatic int prod_w(input int data_w, input int w_w);
    return data_w + 1 + w_w;
  endfunction
endpackage

// File: rtl/bicubic_round_clamp.sv
// bicubic_round_clamp: adds two partial sums, rounds half-up, renormalises by 2^WF and
// clamps to the unsigned pixel range, flagging saturation at either end.
module bicubic_round_clamp import bicubic_tap_mac_pkg::*; #(
  parameter int IN_W   = prod_w(PIX_W, WGT_W) + 1,
  parameter int DATA_W = PIX_W,
  parameter int WF     = WF_DEFAULT
) (
  input  logic signed [IN_W-1:0]   a_i,
  input  logic signed [IN_W-1:0]   b_i,
  output logic        [DATA_W-1:0] pix_o,
  output logic                     sat_o
);
  localparam logic signed [IN_W:0] HALF = (IN_W+1)'(1) << (WF - 1);
  logic signed [IN_W:0] t, r;
  logic neg, hi;
  always_comb begin
    t = {a_i[IN_W-1], a_i} + {b_i[IN_W-1], b_i} + HALF;
    r = t >>> WF;
    neg = r[IN_W];
    hi = !neg && |r[IN_W-1:DATA_W];
    pix_o = neg ? '0 : hi ? '1 : r[DATA_W-1:0];
    sat_o = neg || hi;
  end
endmodule

// File: rtl/bicubic_tap_mac.sv
// bicubic_tap_mac: 4-tap multiply-accumulate of pixels by bicubic weights, three-stage
// pipeline with valid/ready on both sides; one interpolated pixel per accepted beat.
module bicubic_tap_mac import bicubic_tap_mac_pkg::*; #(
  parameter int DATA_W = PIX_W,
  parameter int W_W    = WGT_W,
  parameter int WF     = WF_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic        [DATA_W-1:0] p0,
  input  logic        [DATA_W-1:0] p1,
  input  logic        [DATA_W-1:0] p2,
  input  logic        [DATA_W-1:0] p3,
  input  logic signed [W_W-1:0]    w0,
  input  logic signed [W_W-1:0]    w1,
  input  logic signed [W_W-1:0]    w2,
  input  logic signed [W_W-1:0]    w3,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic        [DATA_W-1:0] out_pix,
  output logic                    out_sat
);
  localparam int PW = prod_w(DATA_W, W_W);
  logic en;
  logic        [DATA_W-1:0] p [4];
  logic signed [W_W-1:0]    w [4];
  logic signed [PW-1:0]     prod_d [4];
  logic signed [PW-1:0]     prod_q [4];
  logic signed [PW:0]       s01_d, s23_d, s01_q, s23_q;
  logic                     v1_q, v2_q, out_valid_q, out_sat_q, sat_d;
  logic        [DATA_W-1:0] out_pix_q, pix_d;
  assign p = '{p0, p1, p2, p3};
  assign w = '{w0, w1, w2, w3};
  // The whole pipe advances together; a stalled output freezes every stage.
  assign en = !out_valid_q || out_ready;
  assign in_ready = en;
  assign out_valid = out_valid_q;
  assign out_pix = out_pix_q;
  assign out_sat = out_sat_q;
  always_comb begin
    for (int i = 0; i < 4; i++) prod_d[i] = PW'($signed({1'b0, p[i]})) * PW'(w[i]);
    s01_d = {prod_q[0][PW-1], prod_q[0]} + {prod_q[1][PW-1], prod_q[1]};
    s23_d = {prod_q[2][PW-1], prod_q[2]} + {prod_q[3][PW-1], prod_q[3]};
  end
  bicubic_round_clamp #(.IN_W(PW + 1), .DATA_W(DATA_W), .WF(WF)) u_round_clamp (
    .a_i  (s01_q),
    .b_i  (s23_q),
    .pix_o(pix_d),
    .sat_o(sat_d)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prod_q <= '{default: '0};
      s01_q <= '0;
      s23_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pix_q <= '0;
      out_sat_q <= 1'b0;
    end else if (en) begin
      prod_q <= prod_d;
      s01_q <= s01_d;
      s23_q <= s23_d;
      v1_q <= in_valid;
      v2_q <= v1_q;
      out_valid_q <= v2_q;
      out_pix_q <= pix_d;
      out_sat_q <= sat_d;
    end
endmodule

// File: tb/tb_bicubic_tap_mac.sv
// tb_bicubic_tap_mac: directed and random beats; expectations queued at accept, popped by a monitor.
module tb_bicubic_tap_mac;
  logic clk = 0, rst_n, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic        [7:0]  p [4];
  logic signed [17:0] w [4];
  logic        [7:0]  out_pix;
  typedef struct { int pix; bit sat; int stamp; } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, en_cnt = 0;
  bit rand_or = 0;
  bicubic_tap_mac dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .p0(p[0]), .p1(p[1]), .p2(p[2]), .p3(p[3]),
    .w0(w[0]), .w1(w[1]), .w2(w[2]), .w3(w[3]),
    .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: exact dot product, floor((sum + half) / one), then clamp to 0..255.
  function automatic void model(input int pa[4], input int wa[4], output int pix, output bit sat);
    longint s = 8192, r;
    for (int i = 0; i < 4; i++) s += longint'(pa[i]) * longint'(wa[i]);
    r = (s >= 0) ? s / 16384 : -((-s + 16383) / 16384);
    sat = (r < 0) || (r > 255);
    pix = (r < 0) ? 0 : (r > 255) ? 255 : int'(r);
  endfunction
  task automatic send(input int pa[4], input int wa[4], input bit use_exp, input int ep, input bit es);
    exp_t e;
    int k = 0;
    for (int i = 0; i < 4; i++) begin
      p[i] = 8'(pa[i]);
      w[i] = 18'(wa[i]);
    end
    in_valid = 1;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 1000);
    if (!in_ready) begin
      $display("FAIL send_timeout: in_ready stuck at 0");
      $fatal(1);
    end
    @(posedge clk);
    #1;
    if (use_exp) begin
      e.pix = ep;
      e.sat = es;
    end else model(pa, wa, e.pix, e.sat);
    e.stamp = en_cnt;
    sb.push_back(e);
  endtask
  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  // Monitor: handshakes are evaluated at the negedge, ahead of the posedge that commits them.
  initial begin
    bit prev_stall = 0;
    int held_pix = 0, held_sat = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        prev_stall = 0;
        continue;
      end
      if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
      if (prev_stall && out_valid) begin
        chk("hold_pix", out_pix, held_pix);
        chk("hold_sat", out_sat, held_sat);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got pix %0d with nothing expected", out_pix);
        end else begin
          e = sb.pop_front();
          chk("out_pix", out_pix, e.pix);
          chk("out_sat", out_sat, e.sat);
          // The accepting clock is already counted when the stamp is taken.
          chk("latency", en_cnt - e.stamp, 2);
        end
      end
      prev_stall = out_valid && !out_ready;
      held_pix = out_pix;
      held_sat = out_sat;
      if (in_ready) en_cnt++;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end
  initial begin
    int ident[4] = '{0, 16384, 0, 0};
    int half[4] = '{-1024, 9216, 9216, -1024};
    int pa[4], wa[4];
    int k;
    rst_n = 0;
    in_valid = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      p[i] = 0;
      w[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pix", out_pix, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;
    @(posedge clk);
    #1;
    send('{10, 200, 30, 40}, ident, 1, 200, 0);
    idle(4);
    send('{0, 100, 100, 0}, half, 1, 113, 0);
    send('{0, 255, 255, 0}, half, 1, 255, 1);
    send('{255, 0, 0, 255}, half, 1, 0, 1);
    idle(5);
    send('{0, 11, 0, 0}, ident, 1, 11, 0);
    idle(1);
    send('{0, 12, 0, 0}, ident, 1, 12, 0);
    send('{0, 13, 0, 0}, ident, 1, 13, 0);
    idle(6);
    fork
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1;
      end
    join_none
    for (int i = 0; i < 20; i++) send('{0, i, 0, 0}, ident, 1, i, 0);
    idle(10);
    chk("bp_drained", sb.size(), 0);
    for (int i = 0; i < 5; i++) send('{0, 50 + i, 0, 0}, ident, 1, 50 + i, 0);
    in_valid = 0;
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);
    @(posedge clk);
    #1;
    send('{0, 77, 0, 0}, ident, 1, 77, 0);
    idle(6);
    rand_or = 1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      for (int i = 0; i < 4; i++) pa[i] = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) wa[i] = int'($urandom_range(0, 262143)) - 131072;
      end else begin
        wa[0] = int'($urandom_range(0, 4096)) - 2048;
        wa[1] = int'($urandom_range(0, 12000));
        wa[2] = int'($urandom_range(0, 12000));
        wa[3] = 16384 - wa[0] - wa[1] - wa[2];
      end
      send(pa, wa, 0, 0, 0);
    end
    in_valid = 0;
    rand_or = 0;
    out_ready = 1;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("final_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
